// File: rtl/ysyx_22050598_pipe_reg_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050598_pipe_reg_skid_pkg
// Brief    : Shared types and constants for the generic pipeline stage
//            register: stage state encoding, per-boundary payload widths
//            and the WB bundle field layout.
// Revision : 1.0  initial release
// ============================================================================
package ysyx_22050598_pipe_reg_skid_pkg;

  // Stage register state; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

  // WB bundle: {rd_data[63:0], rd_en, rd_idx[4:0], ebreak}
  localparam int unsigned c_wb_dw           = 71;
  localparam int unsigned c_wb_ebreak_bit   = 0;
  localparam int unsigned c_wb_rd_idx_lsb   = 1;
  localparam int unsigned c_wb_rd_idx_w     = 5;
  localparam int unsigned c_wb_rd_en_bit    = 6;
  localparam int unsigned c_wb_rd_data_lsb  = 7;
  localparam int unsigned c_wb_rd_data_w    = 64;

  // Number of entries held in a given state.
  function automatic logic [1:0] ps_occupancy(input ps_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      PS_EMPTY: n = 2'd0;
      PS_BUSY:  n = 2'd1;
      PS_FULL:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050598_pipe_reg_skid_dfflrn.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050598_sirv_gnrl_dfflrn
// Brief    : Load-enable flop bank with optional asynchronous active-low
//            reset to a parametrised value.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22050598_sirv_gnrl_dfflrn
  import ysyx_22050598_pipe_reg_skid_pkg::*;
#(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0,
  parameter bit            HAS_RST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_q;

  generate
    if (HAS_RST) begin : g_rst
      // Load on enable; asynchronous clear to RST_VAL while rst is low.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_q <= RST_VAL;
        end else if (i_en) begin
          r_q <= i_d;
        end
      end
    end else begin : g_norst
      // Load on enable; contents undefined until first load.
      always_ff @(posedge clk) begin
        if (i_en) begin
          r_q <= i_d;
        end
      end
    end
  endgenerate

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050598_pipe_reg_skid.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050598_pipe_reg_skid
// Brief    : Generic valid/ready pipeline stage register. With SKID=1 it
//            holds up to two entries (main + skid) and presents a registered
//            in_ready; with SKID=0 it holds one entry and in_ready is
//            combinational. Provides flush, occupancy and a saturating
//            back-pressure cycle counter.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22050598_pipe_reg_skid
  import ysyx_22050598_pipe_reg_skid_pkg::*;
#(
  parameter int DW       = 71,
  parameter int SKID     = 1,
  parameter int RST_DATA = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [1:0]       occupancy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam bit               c_rst_data = (RST_DATA != 0);

  logic [1:0]       r_state;
  ps_state_e        w_state;
  ps_state_e        w_state_nxt;
  logic [DW-1:0]    r_main;
  logic [DW-1:0]    r_skid;
  logic [DW-1:0]    w_main_nxt;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_stall;
  logic             w_cnt_sat;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_cnt;

  assign w_state    = ps_state_e'(r_state);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Next state and data-load enables. With SKID=0 the combinational
  // in_ready forbids an accept while stalled, so FULL is never reached and
  // the same transition table serves both modes.
  always_comb begin
    w_state_nxt = w_state;
    w_main_en   = 1'b0;
    w_main_nxt  = in_data;
    w_skid_en   = 1'b0;
    case (w_state)
      PS_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = PS_BUSY;
          w_main_en   = 1'b1;
        end
      end
      PS_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_en   = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = PS_FULL;
          w_skid_en   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = PS_EMPTY;
        end
      end
      PS_FULL: begin
        if (w_out_fire) begin
          w_state_nxt = PS_BUSY;
          w_main_en   = 1'b1;
          w_main_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = PS_EMPTY;
      end
    endcase
    // Flush discards everything, including a same-cycle accept; the data
    // registers keep their old contents since they are masked by valid.
    if (flush) begin
      w_state_nxt = PS_EMPTY;
      w_main_en   = 1'b0;
      w_skid_en   = 1'b0;
    end
  end

  ysyx_22050598_sirv_gnrl_dfflrn #(
    .DW      (2),
    .RST_VAL (2'(PS_EMPTY)),
    .HAS_RST (1'b1)
  ) u_state (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (2'(w_state_nxt)),
    .o_q  (r_state)
  );

  ysyx_22050598_sirv_gnrl_dfflrn #(
    .DW      (DW),
    .RST_VAL ({DW{1'b0}}),
    .HAS_RST (c_rst_data)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_main_en),
    .i_d  (w_main_nxt),
    .o_q  (r_main)
  );

  generate
    if (SKID != 0) begin : g_skid
      ysyx_22050598_sirv_gnrl_dfflrn #(
        .DW      (DW),
        .RST_VAL ({DW{1'b0}}),
        .HAS_RST (c_rst_data)
      ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_skid_en),
        .i_d  (in_data),
        .o_q  (r_skid)
      );

      // in_ready is a flop: it only reflects whether the next state has a
      // free slot, so out_ready never reaches it combinationally.
      logic r_in_ready;
      ysyx_22050598_sirv_gnrl_dfflrn #(
        .DW      (1),
        .RST_VAL (1'b1),
        .HAS_RST (1'b1)
      ) u_in_ready (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_d  (w_state_nxt != PS_FULL),
        .o_q  (r_in_ready)
      );
      assign in_ready = r_in_ready;
    end else begin : g_noskid
      assign r_skid   = {DW{1'b0}};
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Back-pressure counter: clear wins over increment, holds at all-ones.
  assign w_stall   = out_valid & ~out_ready;
  assign w_cnt_sat = &r_cnt;
  assign w_cnt_en  = cnt_clr | (w_stall & ~w_cnt_sat);
  assign w_cnt_nxt = cnt_clr ? {CNT_W{1'b0}} : (r_cnt + c_cnt_one);

  ysyx_22050598_sirv_gnrl_dfflrn #(
    .DW      (CNT_W),
    .RST_VAL ({CNT_W{1'b0}}),
    .HAS_RST (1'b1)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_cnt_en),
    .i_d  (w_cnt_nxt),
    .o_q  (r_cnt)
  );

  assign out_valid = (w_state != PS_EMPTY);
  assign out_data  = r_main;
  assign occupancy = ps_occupancy(w_state);
  assign stall_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050598_pipe_reg_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050598_pipe_reg_skid
// Brief    : Self-checking bench for the pipeline stage register. Three
//            instances: A (SKID=1), B (SKID=0), C (SKID=1, CNT_W=3). A and B
//            are compared each cycle against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050598_pipe_reg_skid;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A
  logic          a_flush = 0, a_in_valid = 0, a_out_ready = 0, a_cnt_clr = 0;
  logic [DW-1:0] a_in_data = '0;
  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;
  logic [15:0]   a_stall;

  // Instance B
  logic          b_flush = 0, b_in_valid = 0, b_out_ready = 0, b_cnt_clr = 0;
  logic [DW-1:0] b_in_data = '0;
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;
  logic [15:0]   b_stall;

  // Instance C
  logic          c_flush = 0, c_in_valid = 0, c_out_ready = 0, c_cnt_clr = 0;
  logic [DW-1:0] c_in_data = '0;
  logic          c_in_ready, c_out_valid;
  logic [DW-1:0] c_out_data;
  logic [1:0]    c_occ;
  logic [2:0]    c_stall;

  ysyx_22050598_pipe_reg_skid #(.DW(DW), .SKID(1), .RST_DATA(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .occupancy(a_occ), .cnt_clr(a_cnt_clr), .stall_cnt(a_stall)
  );

  ysyx_22050598_pipe_reg_skid #(.DW(DW), .SKID(0), .RST_DATA(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .occupancy(b_occ), .cnt_clr(b_cnt_clr), .stall_cnt(b_stall)
  );

  ysyx_22050598_pipe_reg_skid #(.DW(DW), .SKID(1), .RST_DATA(1), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .occupancy(c_occ), .cnt_clr(c_cnt_clr), .stall_cnt(c_stall)
  );

  // Reference models: FIFO contents, registered ready (A) and stall count.
  logic [DW-1:0] qa[$];
  bit            ma_rdy = 1'b1;
  int            ma_cnt = 0;
  logic [DW-1:0] qb[$];
  int            mb_cnt = 0;
  logic [DW-1:0] b_seen[$];

  // One clock of instance A: drive, compare against the model, advance.
  task automatic cycle_a(input bit v, input logic [DW-1:0] d, input bit ordy,
                         input bit fl, input bit clr);
    bit inf, outf;
    a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_flush = fl; a_cnt_clr = clr;
    #1;
    checks++;
    if (a_out_valid !== (qa.size() != 0)) begin
      errors++; $display("FAIL a_out_valid got %b exp %b", a_out_valid, qa.size() != 0);
    end
    checks++;
    if (a_occ !== 2'(qa.size())) begin
      errors++; $display("FAIL a_occupancy got %0d exp %0d", a_occ, qa.size());
    end
    checks++;
    if (a_in_ready !== ma_rdy) begin
      errors++; $display("FAIL a_in_ready got %b exp %b", a_in_ready, ma_rdy);
    end
    checks++;
    if (a_stall !== 16'(ma_cnt)) begin
      errors++; $display("FAIL a_stall_cnt got %0d exp %0d", a_stall, ma_cnt);
    end
    if (qa.size() != 0) begin
      checks++;
      if (a_out_data !== qa[0]) begin
        errors++; $display("FAIL a_out_data got %h exp %h", a_out_data, qa[0]);
      end
    end
    inf  = v && ma_rdy;
    outf = (qa.size() != 0) && ordy;
    if (clr) ma_cnt = 0;
    else if (qa.size() != 0 && !ordy && ma_cnt < 65535) ma_cnt++;
    if (fl) qa.delete();
    else begin
      if (outf) void'(qa.pop_front());
      if (inf) qa.push_back(d);
    end
    ma_rdy = (qa.size() < 2);
    @(posedge clk); #1;
  endtask

  // One clock of instance B: single entry, ready = empty or downstream ready.
  task automatic cycle_b(input bit v, input logic [DW-1:0] d, input bit ordy,
                         input bit fl, input bit clr);
    bit inf, outf, erdy;
    b_in_valid = v; b_in_data = d; b_out_ready = ordy; b_flush = fl; b_cnt_clr = clr;
    #1;
    erdy = (qb.size() == 0) || ordy;
    checks++;
    if (b_out_valid !== (qb.size() != 0)) begin
      errors++; $display("FAIL b_out_valid got %b exp %b", b_out_valid, qb.size() != 0);
    end
    checks++;
    if (b_occ !== 2'(qb.size())) begin
      errors++; $display("FAIL b_occupancy got %0d exp %0d", b_occ, qb.size());
    end
    checks++;
    if (b_in_ready !== erdy) begin
      errors++; $display("FAIL b_in_ready got %b exp %b", b_in_ready, erdy);
    end
    checks++;
    if (b_stall !== 16'(mb_cnt)) begin
      errors++; $display("FAIL b_stall_cnt got %0d exp %0d", b_stall, mb_cnt);
    end
    if (qb.size() != 0) begin
      checks++;
      if (b_out_data !== qb[0]) begin
        errors++; $display("FAIL b_out_data got %h exp %h", b_out_data, qb[0]);
      end
    end
    inf  = v && erdy;
    outf = (qb.size() != 0) && ordy;
    if (outf) b_seen.push_back(b_out_data);
    if (clr) mb_cnt = 0;
    else if (qb.size() != 0 && !ordy && mb_cnt < 65535) mb_cnt++;
    if (fl) qb.delete();
    else begin
      if (outf) void'(qb.pop_front());
      if (inf) qb.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    a_in_valid = 1; a_in_data = 16'h1A; a_out_ready = 1;
    #1 rst = 1'b0;
    #11;
    checks++;
    if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1 || a_stall !== 16'd0) begin
      errors++;
      $display("FAIL reset_a got v=%b occ=%0d rdy=%b cnt=%0d exp v=0 occ=0 rdy=1 cnt=0",
               a_out_valid, a_occ, a_in_ready, a_stall);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_occ !== 2'd0 || c_stall !== 3'd0) begin
      errors++;
      $display("FAIL reset_bc got bv=%b bocc=%0d ccnt=%0d exp 0 0 0", b_out_valid, b_occ, c_stall);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_first_xfer();
    cycle_a(1, 16'h1A, 1, 0, 0);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 16'h1A || a_occ !== 2'd1) begin
      errors++;
      $display("FAIL first_xfer got v=%b d=%h occ=%0d exp v=1 d=001a occ=1",
               a_out_valid, a_out_data, a_occ);
    end
    cycle_a(0, 16'h0, 1, 0, 0);
    cycle_a(0, 16'h0, 1, 0, 0);
  endtask

  task automatic test_skid_fill();
    cycle_a(1, 16'h1, 0, 0, 0);
    cycle_a(1, 16'h2, 0, 0, 0);
    checks++;
    if (a_in_ready !== 1'b0 || a_occ !== 2'd2) begin
      errors++; $display("FAIL skid_full got rdy=%b occ=%0d exp rdy=0 occ=2", a_in_ready, a_occ);
    end
    cycle_a(1, 16'h3, 0, 0, 0);
    cycle_a(1, 16'h3, 1, 0, 0);
    cycle_a(1, 16'h3, 1, 0, 0);
    cycle_a(0, 16'h0, 1, 0, 0);
    cycle_a(0, 16'h0, 1, 0, 0);
  endtask

  task automatic test_flush();
    cycle_a(1, 16'h21, 0, 0, 0);
    cycle_a(1, 16'h22, 0, 0, 0);
    cycle_a(1, 16'h23, 0, 1, 0);
    checks++;
    if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1", a_out_valid, a_occ, a_in_ready);
    end
    repeat (3) cycle_a(0, 16'h0, 1, 0, 0);
  endtask

  task automatic test_stall_cnt();
    cycle_a(0, 16'h0, 1, 0, 1);
    cycle_a(1, 16'h55, 0, 0, 0);
    repeat (5) cycle_a(0, 16'h0, 0, 0, 0);
    checks++;
    if (a_stall !== 16'd5) begin
      errors++; $display("FAIL stall_cnt5 got %0d exp 5", a_stall);
    end
    cycle_a(0, 16'h0, 0, 0, 1);
    checks++;
    if (a_stall !== 16'd0) begin
      errors++; $display("FAIL stall_clr got %0d exp 0", a_stall);
    end
    cycle_a(0, 16'h0, 1, 0, 0);
  endtask

  task automatic test_random_a();
    for (int i = 0; i < 400; i++) begin
      cycle_a(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0));
    end
  endtask

  task automatic test_noskid();
    b_seen.delete();
    cycle_b(1, 16'h10, 1, 0, 0);
    cycle_b(1, 16'h11, 0, 0, 0);
    cycle_b(1, 16'h11, 1, 0, 0);
    cycle_b(1, 16'h12, 0, 0, 0);
    cycle_b(1, 16'h12, 1, 0, 0);
    cycle_b(0, 16'h0, 1, 0, 0);
    checks++;
    if (b_seen.size() != 3 || b_seen[0] !== 16'h10 || b_seen[1] !== 16'h11 || b_seen[2] !== 16'h12) begin
      errors++; $display("FAIL noskid_order got %0d items exp 10,11,12", b_seen.size());
    end
    for (int i = 0; i < 300; i++) begin
      cycle_b(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0));
    end
  endtask

  task automatic test_saturate();
    c_in_valid = 1; c_in_data = 16'h5; c_out_ready = 0;
    @(posedge clk); #1;
    c_in_valid = 0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (c_stall !== 3'd7 || c_out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_sat got cnt=%0d v=%b exp cnt=7 v=1", c_stall, c_out_valid);
    end
    c_cnt_clr = 1;
    @(posedge clk); #1;
    c_cnt_clr = 0;
    checks++;
    if (c_stall !== 3'd0) begin
      errors++; $display("FAIL stall_sat_clr got %0d exp 0", c_stall);
    end
  endtask

  task automatic test_async_reset();
    cycle_a(1, 16'h31, 0, 0, 0);
    cycle_a(1, 16'h32, 0, 0, 0);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== 16'h0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got v=%b occ=%0d d=%h rdy=%b exp v=0 occ=0 d=0000 rdy=1",
               a_out_valid, a_occ, a_out_data, a_in_ready);
    end
    qa.delete(); ma_rdy = 1'b1; ma_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle_a(0, 16'h0, 1, 0, 0);
    cycle_a(1, 16'h44, 1, 0, 0);
    cycle_a(0, 16'h0, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_xfer();
    test_skid_fill();
    test_flush();
    test_stall_cnt();
    test_random_a();
    test_noskid();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
